ami_req_merge2: RTL and testbench

- Sits directly downstream of the DNN driver's two AMI request ports (mem_reqs[1:0] / mem_resps[1:0]).
- Merges both ports onto one AMI memory channel through a registered output stage.
- Routes in-order read responses back to the originating port using a tag FIFO.
- Lets a DNN app with two memory ports run on a single memory slot.

---
 rtl/ami_req_merge2.sv | 165 ++++++++++++++++
 tb/tb_ami_req_merge2.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ami_req_merge2.sv
// ami_req_merge2: folds the two AMI request ports of a DNN driver onto one
// memory channel. Requests pass through a single registered holding stage;
// a tag FIFO remembers which port issued each read so that the in-order
// read responses can be steered back to their originator.
module ami_req_merge2 #(
  parameter int ADDR_W        = 64,
  parameter int DATA_W        = 512,
  parameter int SIZE_W        = 64,
  parameter int TAG_LOG_DEPTH = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  // port 0
  input  logic                     in0_req_valid,
  input  logic                     in0_req_is_write,
  input  logic [ADDR_W-1:0]        in0_req_addr,
  input  logic [DATA_W-1:0]        in0_req_data,
  input  logic [SIZE_W-1:0]        in0_req_size,
  output logic                     in0_req_grant,
  output logic                     in0_resp_valid,
  output logic [DATA_W-1:0]        in0_resp_data,
  output logic [SIZE_W-1:0]        in0_resp_size,
  input  logic                     in0_resp_grant,
  // port 1
  input  logic                     in1_req_valid,
  input  logic                     in1_req_is_write,
  input  logic [ADDR_W-1:0]        in1_req_addr,
  input  logic [DATA_W-1:0]        in1_req_data,
  input  logic [SIZE_W-1:0]        in1_req_size,
  output logic                     in1_req_grant,
  output logic                     in1_resp_valid,
  output logic [DATA_W-1:0]        in1_resp_data,
  output logic [SIZE_W-1:0]        in1_resp_size,
  input  logic                     in1_resp_grant,
  // merged memory channel
  output logic                     out_req_valid,
  output logic                     out_req_is_write,
  output logic [ADDR_W-1:0]        out_req_addr,
  output logic [DATA_W-1:0]        out_req_data,
  output logic [SIZE_W-1:0]        out_req_size,
  input  logic                     out_req_grant,
  input  logic                     out_resp_valid,
  input  logic [DATA_W-1:0]        out_resp_data,
  input  logic [SIZE_W-1:0]        out_resp_size,
  output logic                     out_resp_grant,
  // status
  output logic [TAG_LOG_DEPTH:0]   outstanding,
  output logic                     err_orphan_resp
);

  localparam int                     DEPTH   = 1 << TAG_LOG_DEPTH;
  localparam logic [TAG_LOG_DEPTH:0]   CNT_ONE = 1;
  localparam logic [TAG_LOG_DEPTH-1:0] PTR_ONE = 1;

  typedef struct packed {
    logic              is_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [SIZE_W-1:0] size;
  } req_t;

  req_t [1:0] in_req;
  logic [1:0] in_vld;
  logic [1:0] cand;
  logic [1:0] gnt;

  req_t hold_q;
  logic out_vld_q;
  logic rr_q;        // last winner; the other port wins the next tie

  logic [DEPTH-1:0]         tag_mem;
  logic [TAG_LOG_DEPTH-1:0] wr_ptr, rd_ptr;
  logic [TAG_LOG_DEPTH:0]   tag_cnt;
  logic                     err_q;

  logic fifo_empty, fifo_full, head_tag;
  logic pop, push, free, load, sel;

  assign in_req[0] = {in0_req_is_write, in0_req_addr, in0_req_data, in0_req_size};
  assign in_req[1] = {in1_req_is_write, in1_req_addr, in1_req_data, in1_req_size};
  assign in_vld    = {in1_req_valid, in0_req_valid};

  // ---------------- response routing ----------------
  assign fifo_empty = (tag_cnt == '0);
  assign fifo_full  = tag_cnt[TAG_LOG_DEPTH];
  assign head_tag   = tag_mem[rd_ptr];

  // With no tag recorded the response is an orphan and is simply dropped.
  assign out_resp_grant = fifo_empty | (head_tag ? in1_resp_grant : in0_resp_grant);
  assign pop            = out_resp_valid & out_resp_grant & ~fifo_empty;

  assign in0_resp_valid = ~reset & out_resp_valid & ~fifo_empty & ~head_tag;
  assign in1_resp_valid = ~reset & out_resp_valid & ~fifo_empty &  head_tag;
  assign in0_resp_data  = out_resp_data;
  assign in1_resp_data  = out_resp_data;
  assign in0_resp_size  = out_resp_size;
  assign in1_resp_size  = out_resp_size;

  // ---------------- candidacy and arbitration ----------------
  // A read may take the last tag slot if a response frees one this cycle.
  for (genvar i = 0; i < 2; i++) begin : g_port
    assign cand[i] = in_vld[i] & (in_req[i].is_write | ~(fifo_full & ~pop));
  end

  assign free  = ~out_vld_q | out_req_grant;
  assign sel   = (&cand) ? ~rr_q : cand[1];
  assign load  = ~reset & free & (|cand);
  assign gnt   = {load & sel, load & ~sel};
  assign push  = load & ~in_req[sel].is_write;

  assign in0_req_grant = gnt[0];
  assign in1_req_grant = gnt[1];

  // Holding register: loads on a free slot, otherwise keeps fields stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_vld_q <= 1'b0;
      hold_q    <= '0;
      rr_q      <= 1'b1;
    end else if (load) begin
      out_vld_q <= 1'b1;
      hold_q    <= in_req[sel];
      rr_q      <= sel;
    end else if (free) begin
      out_vld_q <= 1'b0;
    end
  end

  assign out_req_valid    = out_vld_q;
  assign out_req_is_write = hold_q.is_write;
  assign out_req_addr     = hold_q.addr;
  assign out_req_data     = hold_q.data;
  assign out_req_size     = hold_q.size;

  // ---------------- tag FIFO ----------------
  // Tag storage needs no reset: validity is tracked by tag_cnt.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= sel;
  end

  // Pointers and occupancy; push and pop together leave the count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tag_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      tag_cnt <= tag_cnt + CNT_ONE;
      else if (pop && !push) tag_cnt <= tag_cnt - CNT_ONE;
    end
  end

  assign outstanding = tag_cnt;

  // Sticky orphan-response flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset)                             err_q <= 1'b0;
    else if (out_resp_valid && fifo_empty) err_q <= 1'b1;
  end

  assign err_orphan_resp = err_q;

endmodule

// File: tb/tb_ami_req_merge2.sv
// Bench for ami_req_merge2: expected merged requests and response routes are
// queued as stimulus is driven; a negedge monitor drains the request queue.
module tb_ami_req_merge2;
  localparam int AW = 64, DW = 512, SW = 64, TL = 5;

  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  logic          in0_req_valid = 0, in0_req_is_write = 0, in0_req_grant;
  logic [AW-1:0] in0_req_addr = '0;
  logic [DW-1:0] in0_req_data = '0;
  logic [SW-1:0] in0_req_size = '0;
  logic          in0_resp_valid, in0_resp_grant = 0;
  logic [DW-1:0] in0_resp_data;
  logic [SW-1:0] in0_resp_size;
  logic          in1_req_valid = 0, in1_req_is_write = 0, in1_req_grant;
  logic [AW-1:0] in1_req_addr = '0;
  logic [DW-1:0] in1_req_data = '0;
  logic [SW-1:0] in1_req_size = '0;
  logic          in1_resp_valid, in1_resp_grant = 0;
  logic [DW-1:0] in1_resp_data;
  logic [SW-1:0] in1_resp_size;
  logic          out_req_valid, out_req_is_write, out_req_grant = 0;
  logic [AW-1:0] out_req_addr;
  logic [DW-1:0] out_req_data;
  logic [SW-1:0] out_req_size;
  logic          out_resp_valid = 0, out_resp_grant;
  logic [DW-1:0] out_resp_data = '0;
  logic [SW-1:0] out_resp_size = '0;
  logic [TL:0]   outstanding;
  logic          err_orphan_resp;

  ami_req_merge2 #(.ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW), .TAG_LOG_DEPTH(TL)) dut (
    .clk(clk), .reset(reset),
    .in0_req_valid(in0_req_valid), .in0_req_is_write(in0_req_is_write),
    .in0_req_addr(in0_req_addr), .in0_req_data(in0_req_data), .in0_req_size(in0_req_size),
    .in0_req_grant(in0_req_grant), .in0_resp_valid(in0_resp_valid),
    .in0_resp_data(in0_resp_data), .in0_resp_size(in0_resp_size), .in0_resp_grant(in0_resp_grant),
    .in1_req_valid(in1_req_valid), .in1_req_is_write(in1_req_is_write),
    .in1_req_addr(in1_req_addr), .in1_req_data(in1_req_data), .in1_req_size(in1_req_size),
    .in1_req_grant(in1_req_grant), .in1_resp_valid(in1_resp_valid),
    .in1_resp_data(in1_resp_data), .in1_resp_size(in1_resp_size), .in1_resp_grant(in1_resp_grant),
    .out_req_valid(out_req_valid), .out_req_is_write(out_req_is_write),
    .out_req_addr(out_req_addr), .out_req_data(out_req_data), .out_req_size(out_req_size),
    .out_req_grant(out_req_grant), .out_resp_valid(out_resp_valid),
    .out_resp_data(out_resp_data), .out_resp_size(out_resp_size), .out_resp_grant(out_resp_grant),
    .outstanding(outstanding), .err_orphan_resp(err_orphan_resp)
  );

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
  } req_t;

  req_t exp_q[$];
  logic port_q[$];
  req_t mon_e;
  int   checks = 0, failures = 0;

  task automatic drv0(input logic v, input logic w, input logic [AW-1:0] a);
    in0_req_valid = v; in0_req_is_write = w; in0_req_addr = a;
    in0_req_data = {8{a}}; in0_req_size = SW'(64);
  endtask

  task automatic drv1(input logic v, input logic w, input logic [AW-1:0] a);
    in1_req_valid = v; in1_req_is_write = w; in1_req_addr = a;
    in1_req_data = {8{a}}; in1_req_size = SW'(32);
  endtask

  task automatic push_exp(input logic w, input logic [AW-1:0] a, input logic [SW-1:0] s);
    exp_q.push_back('{w, a, {8{a}}, s});
  endtask

  // Scoreboard: every accepted merged request must match the queue head.
  always @(negedge clk) begin
    if (!reset && out_req_valid && out_req_grant) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL req_order: unexpected request addr=%0h, queue empty", out_req_addr);
      end else begin
        mon_e = exp_q.pop_front();
        if (out_req_is_write !== mon_e.w || out_req_addr !== mon_e.a ||
            out_req_data !== mon_e.d || out_req_size !== mon_e.s) begin
          failures++;
          $display("FAIL req_fields: got w=%0b addr=%0h size=%0d want w=%0b addr=%0h size=%0d",
                   out_req_is_write, out_req_addr, out_req_size, mon_e.w, mon_e.a, mon_e.s);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    drv0(1, 0, 'h10);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (out_req_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b want=0", out_req_valid); end
    checks++; if ({in1_req_grant, in0_req_grant} !== 2'b00) begin failures++; $display("FAIL rst_req_grant got=%b want=00", {in1_req_grant, in0_req_grant}); end
    checks++; if ({in1_resp_valid, in0_resp_valid} !== 2'b00) begin failures++; $display("FAIL rst_resp_valid got=%b want=00", {in1_resp_valid, in0_resp_valid}); end
    checks++; if (outstanding !== '0) begin failures++; $display("FAIL rst_outstanding got=%0d want=0", outstanding); end
    checks++; if (err_orphan_resp !== 1'b0) begin failures++; $display("FAIL rst_err got=%b want=0", err_orphan_resp); end
    @(posedge clk); #1;
    reset = 1'b0;
    drv0(0, 0, '0);
  endtask

  task automatic test_stream();
    int n0 = 0, n1 = 0;
    logic w;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] rd;
    logic p;
    @(posedge clk); #1;
    out_req_grant = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a0 = 'h2000 + AW'(n0 * 64);
      a1 = 'h3000 + AW'(n1 * 64);
      drv0(1, 0, a0);
      drv1(1, 0, a1);
      w = (i % 2) == 1;
      if (w) push_exp(0, a1, SW'(32)); else push_exp(0, a0, SW'(64));
      port_q.push_back(w);
      @(negedge clk);
      checks++;
      if ({in1_req_grant, in0_req_grant} !== (w ? 2'b10 : 2'b01)) begin
        failures++; $display("FAIL stream_grant[%0d] got=%b want=%b", i, {in1_req_grant, in0_req_grant}, (w ? 2'b10 : 2'b01));
      end
      if (w) n1++; else n0++;
      @(posedge clk); #1;
    end
    drv0(0, 0, '0); drv1(0, 0, '0);
    @(negedge clk);
    checks++; if (outstanding !== 8) begin failures++; $display("FAIL stream_outstanding got=%0d want=8", outstanding); end
    @(posedge clk); #1;
    in0_resp_grant = 1; in1_resp_grant = 1;
    for (int i = 0; i < 8; i++) begin
      rd = DW'('hD0 + i);
      out_resp_valid = 1; out_resp_data = rd;
      @(negedge clk);
      p = port_q.pop_front();
      checks++;
      if ({in1_resp_valid, in0_resp_valid} !== (p ? 2'b10 : 2'b01) ||
          (p ? in1_resp_data : in0_resp_data) !== rd || out_resp_grant !== 1'b1) begin
        failures++; $display("FAIL stream_resp[%0d] got valid=%b grant=%b want valid=%b grant=1",
                             i, {in1_resp_valid, in0_resp_valid}, out_resp_grant, (p ? 2'b10 : 2'b01));
      end
      @(posedge clk); #1;
    end
    out_resp_valid = 0;
    @(negedge clk);
    checks++; if (outstanding !== 0) begin failures++; $display("FAIL stream_drain got=%0d want=0", outstanding); end
  endtask

  task automatic test_hold();
    @(posedge clk); #1;
    out_req_grant = 0;
    drv1(1, 1, 'h4000); push_exp(1, 'h4000, SW'(32));
    @(negedge clk);
    checks++; if (in1_req_grant !== 1'b1) begin failures++; $display("FAIL hold_first_grant got=%b want=1", in1_req_grant); end
    @(posedge clk); #1;
    drv1(1, 1, 'h4040); drv0(1, 1, 'h5000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_req_valid !== 1'b1 || out_req_addr !== 'h4000 || out_req_data !== {8{64'h4000}} ||
          {in1_req_grant, in0_req_grant} !== 2'b00) begin
        failures++; $display("FAIL hold_stable[%0d] got valid=%b addr=%0h grants=%b want valid=1 addr=4000 grants=00",
                             i, out_req_valid, out_req_addr, {in1_req_grant, in0_req_grant});
      end
      @(posedge clk); #1;
    end
    out_req_grant = 1;
    push_exp(1, 'h5000, SW'(64));
    @(negedge clk);
    checks++; if ({in1_req_grant, in0_req_grant} !== 2'b01) begin failures++; $display("FAIL hold_release got=%b want=01", {in1_req_grant, in0_req_grant}); end
    @(posedge clk); #1;
    drv0(0, 0, '0);
    push_exp(1, 'h4040, SW'(32));
    @(negedge clk);
    checks++; if ({in1_req_grant, in0_req_grant} !== 2'b10) begin failures++; $display("FAIL hold_next got=%b want=10", {in1_req_grant, in0_req_grant}); end
    @(posedge clk); #1;
    drv1(0, 0, '0);
    @(negedge clk);
    checks++; if (outstanding !== 0) begin failures++; $display("FAIL hold_writes_no_tag got=%0d want=0", outstanding); end
  endtask

  task automatic test_full();
    logic [AW-1:0] a;
    logic p;
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) begin
      a = 'h6000 + AW'(i * 64);
      drv0(1, 0, a); push_exp(0, a, SW'(64)); port_q.push_back(0);
      @(negedge clk);
      checks++; if (in0_req_grant !== 1'b1) begin failures++; $display("FAIL full_fill[%0d] got=%b want=1", i, in0_req_grant); end
      @(posedge clk); #1;
    end
    a = 'h6000 + AW'(32 * 64);
    drv0(1, 0, a);
    drv1(1, 1, 'h7000); push_exp(1, 'h7000, SW'(32));
    @(negedge clk);
    checks++; if ({in1_req_grant, in0_req_grant} !== 2'b10) begin failures++; $display("FAIL full_write_passes got=%b want=10", {in1_req_grant, in0_req_grant}); end
    checks++; if (outstanding !== 32) begin failures++; $display("FAIL full_count got=%0d want=32", outstanding); end
    @(posedge clk); #1;
    drv1(0, 0, '0);
    @(negedge clk);
    checks++; if (in0_req_grant !== 1'b0) begin failures++; $display("FAIL full_stall got=%b want=0", in0_req_grant); end
    @(posedge clk); #1;
    out_resp_valid = 1; out_resp_data = DW'('hE0);
    in0_resp_grant = 1; in1_resp_grant = 1;
    push_exp(0, a, SW'(64)); port_q.push_back(0);
    @(negedge clk);
    p = port_q.pop_front();
    checks++;
    if (in0_resp_valid !== !p || out_resp_grant !== 1'b1 || in0_req_grant !== 1'b1) begin
      failures++; $display("FAIL full_pop_push got resp_valid0=%b resp_grant=%b req_grant0=%b want 1 1 1",
                           in0_resp_valid, out_resp_grant, in0_req_grant);
    end
    @(posedge clk); #1;
    out_resp_valid = 0; drv0(0, 0, '0);
    @(negedge clk);
    checks++; if (outstanding !== 32) begin failures++; $display("FAIL full_count_same got=%0d want=32", outstanding); end
  endtask

  task automatic test_resp_hold();
    logic p;
    @(posedge clk); #1;
    in0_resp_grant = 1; in1_resp_grant = 1;
    for (int i = 0; i < 32; i++) begin
      out_resp_valid = 1; out_resp_data = DW'(i);
      @(negedge clk);
      p = port_q.pop_front();
      checks++;
      if ({in1_resp_valid, in0_resp_valid} !== (p ? 2'b10 : 2'b01)) begin
        failures++; $display("FAIL drain_route[%0d] got=%b want=%b", i, {in1_resp_valid, in0_resp_valid}, (p ? 2'b10 : 2'b01));
      end
      @(posedge clk); #1;
    end
    out_resp_valid = 0;
    drv1(1, 0, 'h8000); push_exp(0, 'h8000, SW'(32)); port_q.push_back(1);
    @(negedge clk);
    checks++; if (in1_req_grant !== 1'b1 || outstanding !== 0) begin failures++; $display("FAIL rh_issue got grant=%b out=%0d want 1 0", in1_req_grant, outstanding); end
    @(posedge clk); #1;
    drv1(0, 0, '0);
    out_resp_valid = 1; out_resp_data = DW'('hF1);
    in1_resp_grant = 0; in0_resp_grant = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in1_resp_valid !== 1'b1 || in0_resp_valid !== 1'b0 || out_resp_grant !== 1'b0 || outstanding !== 1) begin
        failures++; $display("FAIL rh_hold[%0d] got v1=%b v0=%b grant=%b out=%0d want 1 0 0 1",
                             i, in1_resp_valid, in0_resp_valid, out_resp_grant, outstanding);
      end
      @(posedge clk); #1;
    end
    in1_resp_grant = 1;
    @(negedge clk);
    p = port_q.pop_front();
    checks++;
    if (out_resp_grant !== 1'b1 || in1_resp_valid !== p || in1_resp_data !== DW'('hF1)) begin
      failures++; $display("FAIL rh_release got grant=%b v1=%b want grant=1 v1=%b", out_resp_grant, in1_resp_valid, p);
    end
    @(posedge clk); #1;
    out_resp_valid = 0;
    @(negedge clk);
    checks++; if (outstanding !== 0) begin failures++; $display("FAIL rh_count got=%0d want=0", outstanding); end
  endtask

  task automatic test_orphan_reset();
    logic [AW-1:0] a;
    @(posedge clk); #1;
    out_resp_valid = 1; out_resp_data = DW'('hBAD);
    in0_resp_grant = 0; in1_resp_grant = 0;
    @(negedge clk);
    checks++;
    if (out_resp_grant !== 1'b1 || {in1_resp_valid, in0_resp_valid} !== 2'b00 || err_orphan_resp !== 1'b0) begin
      failures++; $display("FAIL orphan_drop got grant=%b valids=%b err=%b want 1 00 0",
                           out_resp_grant, {in1_resp_valid, in0_resp_valid}, err_orphan_resp);
    end
    @(posedge clk); #1;
    out_resp_valid = 0;
    @(negedge clk);
    checks++; if (err_orphan_resp !== 1'b1) begin failures++; $display("FAIL orphan_set got=%b want=1", err_orphan_resp); end
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (err_orphan_resp !== 1'b1) begin failures++; $display("FAIL orphan_sticky got=%b want=1", err_orphan_resp); end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      a = 'h9000 + AW'(i * 64);
      drv0(1, 0, a); push_exp(0, a, SW'(64)); port_q.push_back(0);
      @(negedge clk);
      checks++; if (in0_req_grant !== 1'b1) begin failures++; $display("FAIL orphan_rd[%0d] got=%b want=1", i, in0_req_grant); end
      @(posedge clk); #1;
    end
    drv0(0, 0, '0);
    drv1(1, 1, 'hA000); push_exp(1, 'hA000, SW'(32));
    @(negedge clk);
    @(posedge clk); #1;
    drv1(0, 0, '0);
    out_req_grant = 0;
    @(negedge clk);
    checks++; if (outstanding !== 3 || out_req_valid !== 1'b1) begin failures++; $display("FAIL pre_reset got out=%0d valid=%b want 3 1", outstanding, out_req_valid); end
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    exp_q.delete(); port_q.delete();
    @(negedge clk);
    checks++;
    if (outstanding !== 0 || out_req_valid !== 1'b0 || err_orphan_resp !== 1'b0) begin
      failures++; $display("FAIL mid_reset got out=%0d valid=%b err=%b want 0 0 0", outstanding, out_req_valid, err_orphan_resp);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_hold();
    test_full();
    test_resp_hold();
    test_orphan_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
